pythag_leg_solver: RTL and testbench

Sequential inverse of the magnitude block: given a hypotenuse R and one leg X, it computes the other leg Y = floor(sqrt(R² − X²)). It sits beside the magnitude unit as its companion: the magnitude unit turns (X, Y) into R, and this block recovers Y from (R, X). It uses a start/busy/done handshake with fixed latency. It produces one result bit per cycle with a restoring bit-serial square root, avoiding a large combinational root.

---
 rtl/pythag_leg_solver.sv | 99 +++++++++
 tb/tb_pythag_leg_solver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pythag_leg_solver.sv
// Recovers the missing leg Y = floor(sqrt(R^2 - X^2)) from hypotenuse R and leg X,
// one result bit per cycle using a restoring bit-serial square root.
module pythag_leg_solver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] r_in,
    input  logic [7:0] x_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] y_out,
    output logic       invalid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;

    logic [1:0]  state_reg;
    logic [7:0]  r_reg;
    logic [7:0]  x_reg;
    logic [15:0] d_reg;
    logic [7:0]  root_reg;
    logic [2:0]  k_reg;
    logic        inv_reg;

    logic [15:0] r_sq;
    logic [15:0] x_sq;
    logic [16:0] diff;
    logic [7:0]  trial;
    logic [15:0] trial_sq;
    logic [7:0]  root_next;

    assign r_sq = {8'd0, r_reg} * {8'd0, r_reg};
    assign x_sq = {8'd0, x_reg} * {8'd0, x_reg};
    // Borrow out of the 17-bit difference means X > R.
    assign diff = {1'b0, r_sq} - {1'b0, x_sq};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_trial
            assign trial[gi] = root_reg[gi] | (k_reg == 3'(gi));
        end
    endgenerate

    assign trial_sq  = {8'd0, trial} * {8'd0, trial};
    assign root_next = (trial_sq <= d_reg) ? trial : root_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            r_reg     <= 8'd0;
            x_reg     <= 8'd0;
            d_reg     <= 16'd0;
            root_reg  <= 8'd0;
            k_reg     <= 3'd0;
            inv_reg   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            y_out     <= 8'd0;
            invalid   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        r_reg     <= r_in;
                        x_reg     <= x_in;
                        busy      <= 1'b1;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    inv_reg   <= diff[16];
                    d_reg     <= diff[16] ? 16'd0 : diff[15:0];
                    k_reg     <= 3'd7;
                    root_reg  <= 8'd0;
                    state_reg <= ST_ITER;
                end
                ST_ITER: begin
                    root_reg <= root_next;
                    k_reg    <= k_reg - 3'd1;
                    if (k_reg == 3'd0) begin
                        y_out     <= root_next;
                        invalid   <= inv_reg;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pythag_leg_solver.sv
// Self-checking bench for pythag_leg_solver: directed cases, reset abort,
// back-to-back protocol and randomized operands against an arithmetic model.
module tb_pythag_leg_solver;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] r_in;
    logic [7:0] x_in;
    logic       busy;
    logic       done;
    logic [7:0] y_out;
    logic       invalid;

    int checks;
    int failures;
    logic [7:0] held_y;
    logic       held_inv;

    pythag_leg_solver dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .r_in    (r_in),
        .x_in    (x_in),
        .busy    (busy),
        .done    (done),
        .y_out   (y_out),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Largest integer whose square does not exceed R^2 - X^2 (0 when X > R).
    function automatic int model_y(input int r, input int x);
        int d;
        int y;
        if (x > r) return 0;
        d = r * r - x * x;
        y = 0;
        while ((y + 1) * (y + 1) <= d) y++;
        return y;
    endfunction

    // One operation: accept at E0, check busy/hold each cycle, done exactly at E9.
    task automatic op(input logic [7:0] r, input logic [7:0] x, input logic [7:0] exp_y,
                      input logic exp_inv, input bit keep_start,
                      input logic [7:0] r_late, input logic [7:0] x_late);
        @(negedge clk);
        start = 1'b1;
        r_in  = r;
        x_in  = x;
        @(posedge clk);
        #1;
        check("busy_e0", busy, 1);
        check("done_e0", done, 0);
        if (!keep_start) start = 1'b0;
        r_in = r_late;
        x_in = x_late;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (i < 9) begin
                check("busy_mid", busy, 1);
                check("done_mid", done, 0);
                check("y_held", y_out, held_y);
            end else begin
                check("done_e9", done, 1);
                check("busy_e9", busy, 0);
                check("y_out", y_out, exp_y);
                check("invalid", invalid, exp_inv);
            end
        end
        $display("op R=%0d X=%0d -> y_out=%0d invalid=%0b (expect %0d/%0b)",
                 r, x, y_out, invalid, exp_y, exp_inv);
        held_y   = exp_y;
        held_inv = exp_inv;
    endtask

    initial begin
        logic [7:0] rr;
        logic [7:0] xx;
        int         my;
        checks   = 0;
        failures = 0;
        held_y   = 8'd0;
        held_inv = 1'b0;
        start    = 1'b0;
        r_in     = 8'd0;
        x_in     = 8'd0;
        rst_n    = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_y", y_out, 0);
        check("rst_inv", invalid, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        op(8'd5, 8'd3, 8'd4, 1'b0, 0, 8'd77, 8'd99);
        op(8'd255, 8'd0, 8'd255, 1'b0, 0, 8'd0, 8'd0);
        op(8'd10, 8'd10, 8'd0, 1'b0, 0, 8'd1, 8'd2);
        op(8'd200, 8'd100, 8'd173, 1'b0, 0, 8'd3, 8'd4);
        op(8'd3, 8'd5, 8'd0, 1'b1, 0, 8'd9, 8'd9);
        op(8'd13, 8'd5, 8'd12, 1'b0, 0, 8'd0, 8'd0);

        // start held high through busy and operands changed: one result, then next op at E10
        op(8'd13, 8'd12, 8'd5, 1'b0, 1, 8'd1, 8'd0);
        op(8'd1, 8'd0, 8'd1, 1'b0, 0, 8'd0, 8'd0);

        // Reset mid-operation at ITER k=3
        @(negedge clk);
        start = 1'b1;
        r_in  = 8'd100;
        x_in  = 8'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_y", y_out, 0);
        check("abort_inv", invalid, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", done, 0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        held_y   = 8'd0;
        held_inv = 1'b0;
        op(8'd17, 8'd8, 8'd15, 1'b0, 0, 8'd0, 8'd0);

        // Boundary sweeps: R=255 against every X, and every R against X=R and X=R+1
        for (int i = 0; i < 256; i++) begin
            xx = 8'(i);
            my = model_y(255, i);
            op(8'd255, xx, 8'(my), 1'b0, 0, 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 255; i++) begin
            rr = 8'(i);
            op(rr, rr, 8'd0, 1'b0, 0, 8'($urandom), 8'($urandom));
            xx = 8'(i + 1);
            op(rr, xx, 8'd0, 1'b1, 0, 8'($urandom), 8'($urandom));
        end

        // Randomized operands, occasionally back-to-back
        for (int i = 0; i < 2000; i++) begin
            rr = 8'($urandom);
            xx = 8'($urandom);
            if ($urandom_range(0, 3) != 0 && xx > rr) xx = 8'($urandom_range(0, int'(rr)));
            my = model_y(int'(rr), int'(xx));
            op(rr, xx, 8'(my), (xx > rr), ($urandom_range(0, 1) == 1),
               8'($urandom), 8'($urandom));
        end
        @(negedge clk);
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
